bcd_serial_adder: RTL
=====================

# bcd_serial_adder

Digit-serial multi-digit BCD adder built around the existing single-digit `bcd_adder`. It accepts two packed DIGITS-wide BCD operands plus a carry-in and walks them least-significant digit first, one digit per clock. The carry is held in a flop between digits. It then presents a registered multi-digit BCD sum and carry-out with a one-cycle `done` pulse. It is the sequencing stage directly upstream of `bcd_adder`: it feeds that block one digit pair and carry per cycle and consumes its `sum`/`carry`.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand; legal range 1–16.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled only while `ready`=1.
- `a`  in  4*DIGITS: operand A, packed BCD, digit 0 at bits [3:0].
- `b`  in  4*DIGITS: operand B, same packing.
- `cin`  in  1: carry into digit 0.
- `ready`  out  1: high only in IDLE.
- `sum`  out  4*DIGITS: registered BCD result, same packing.
- `cout`  out  1: registered carry out of the top digit.
- `done`  out  1: one-cycle pulse; `sum`/`cout` are valid from this cycle on.
- `err`  out  1: registered; set when any digit of `a` or `b` captured at start is greater than 9.

## Operation
- States: IDLE → ADD → DONE → IDLE.
- IDLE, start=1: capture `a`, `b` into shift registers and `cin` into the carry flop. Compute `err` from the captured digits. Clear the digit index. Go to ADD.
- ADD: `bcd_adder` sees the low digit of each shift register and the carry flop. Each edge:
  - shift both operand registers down one digit;
  - shift the adder's `sum` into the top of the result shift register;
  - load the carry flop from the adder's `carry`;
  - increment the index.
- ADD exit: on the edge that processes digit DIGITS-1, load `sum` from the completed result and `cout` from the final carry, then go to DONE.
- DONE: `done`=1 for exactly this cycle. Go to IDLE unconditionally.
- `sum`, `cout` and `err` hold their values until the next accepted start. They never change during ADD.
- `start` is ignored in ADD and DONE. No queuing.
- Non-BCD digits: the computation still runs and `err`=1 is reported. The `sum` value is then don't-care.
- Arithmetic is pure decimal. The maximum result, 99…9 + 99…9 + 1, gives `sum` = all 9s with `cout`=1.

## Timing
- Reset values (asserted asynchronously): state IDLE, `ready`=1, `sum`=0, `cout`=0, `done`=0, `err`=0. Internal shift registers, carry flop and index are all cleared.
- Reset asserted mid-operation aborts immediately. No `done` is produced. Operation resumes in IDLE on the first edge after release.
- `start` sampled at edge E0:
  - `ready`=0 from E0;
  - `sum`/`cout` update at edge E0+DIGITS;
  - `done`=1 in the cycle between E0+DIGITS and E0+DIGITS+1;
  - `ready`=1 again after E0+DIGITS+1.
- Minimum start-to-start spacing is DIGITS+2 cycles.
- `err` updates at E0.
- `ready` and `done` are decoded from the state register only. No combinational path runs from `start` to any output.

## Structure
- Shared package `bcd_pkg`:
  - `BCD_W`=4;
  - `BCD_MAX`=9;
  - state encoding constants `ST_IDLE`, `ST_ADD`, `ST_DONE`.
- The index width is derived as clog2(DIGITS), minimum 1.
- One sub-module: the existing `bcd_adder` (ports `a`, `b`, `carry_in`, `sum`, `carry`), instantiated once.
- Everything else is local:
  - operand and result shift registers;
  - carry flop;
  - index counter;
  - state register;
  - digit-validity check.

## Test plan
All scenarios use DIGITS=4.
- a=0x1234, b=0x5678, cin=0, start at E0 → `sum`=0x6912, `cout`=0, `err`=0; `done` pulses in the cycle after E0+4 only; `ready` is low for 5 cycles.
- a=0x9999, b=0x0001, cin=0 → `sum`=0x0000, `cout`=1; checks carry ripple through every digit.
- a=0x9999, b=0x9999, cin=1 → `sum`=0x9999, `cout`=1; then a=0x0000, b=0x0000, cin=0 → `sum`=0x0000, `cout`=0, confirming the carry flop reloads from `cin`.
- Pulse start again 2 cycles into an operation with different operands → ignored; the first result is unchanged and only one `done` occurs.
- a=0x12A4, b=0x0001 → `err`=1 from E0 and held through `done`. A following valid op clears `err` to 0.
- Drop `rst_n` 2 cycles after start → `ready`=1, `sum`=0, `cout`=0, `done`=0 immediately. No `done` follows. A fresh 0x0005+0x0005 op gives `sum`=0x0010.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD constants and the serial-adder state encoding.
package bcd_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned BCD_MAX = 9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/bcd_adder.sv
// Single-digit BCD adder: sum = a + b + carry_in in decimal.
// Ports: a, b (one BCD digit each), carry_in -> sum (BCD digit), carry.
// Non-BCD input digits produce an unspecified sum.
module bcd_adder
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             carry_in,
  output logic [BCD_W-1:0] sum,
  output logic             carry
);

  logic [BCD_W:0] raw;

  // Binary sum, then +6 correction when the digit overflows past 9.
  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + (BCD_W+1)'(carry_in);
    if (raw > (BCD_W+1)'(BCD_MAX)) begin
      sum   = BCD_W'(raw + (BCD_W+1)'(6));
      carry = 1'b1;
    end else begin
      sum   = raw[BCD_W-1:0];
      carry = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder. Walks the operands LSD first, one digit
// per clock, through a single bcd_adder and presents a registered result.
// Ports: clk, rst_n (async active-low); start (sampled when ready);
//        a, b, cin operands; ready, sum, cout, done (1-cycle pulse), err.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BCD_W*DIGITS-1:0] a,
  input  logic [BCD_W*DIGITS-1:0] b,
  input  logic                    cin,
  output logic                    ready,
  output logic [BCD_W*DIGITS-1:0] sum,
  output logic                    cout,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned W     = BCD_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     a_sr_q, a_sr_d;
  logic [W-1:0]     b_sr_q, b_sr_d;
  logic [W-1:0]     res_sr_q, res_sr_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic [BCD_W-1:0] dig_sum;
  logic             dig_carry;
  logic             bad_digit;
  logic [W-1:0]     res_shift;

  bcd_adder u_digit (
    .a        (a_sr_q[BCD_W-1:0]),
    .b        (b_sr_q[BCD_W-1:0]),
    .carry_in (carry_q),
    .sum      (dig_sum),
    .carry    (dig_carry)
  );

  // Any digit of either incoming operand above 9.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (a[i*BCD_W +: BCD_W] > BCD_W'(BCD_MAX) ||
          b[i*BCD_W +: BCD_W] > BCD_W'(BCD_MAX)) begin
        bad_digit = 1'b1;
      end
    end
  end

  // New digit enters at the top so the last one processed lands in digit DIGITS-1.
  always_comb begin
    res_shift = (res_sr_q >> BCD_W) | (W'(dig_sum) << (W - BCD_W));
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          err_d   = bad_digit;
          idx_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        a_sr_d   = a_sr_q >> BCD_W;
        b_sr_d   = b_sr_q >> BCD_W;
        res_sr_d = res_shift;
        carry_d  = dig_carry;
        idx_d    = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          sum_d   = res_shift;
          cout_d  = dig_carry;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered copies of the next-state decode.
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign err   = err_q;

endmodule
